// File: rtl/fnd_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with an internal prescaler,
// per-digit DP and blink, leading-zero suppression, PWM brightness and
// inputs captured once per frame.
module fnd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BRIGHT_W     = 3,
    parameter int unsigned BLINK_FRAMES = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   bcd_data,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_blank,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int unsigned PC_W   = $clog2(SCAN_DIV);
    localparam int unsigned SEL_W  = $clog2(NUM_DIGITS);
    localparam int unsigned BC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned THR_W  = PC_W + 1;
    localparam int unsigned PROD_W = THR_W + BRIGHT_W;
    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;

    logic [PC_W-1:0]       pc, pc_nxt;
    logic [SEL_W-1:0]      sel, sel_nxt;
    logic [BC_W-1:0]       blink_cnt, blink_cnt_nxt;
    logic                  blink_ph, blink_ph_nxt;
    logic [BCD_W-1:0]      snap_bcd, snap_bcd_nxt;
    logic [NUM_DIGITS-1:0] snap_dp, snap_dp_nxt;
    logic [NUM_DIGITS-1:0] snap_blink, snap_blink_nxt;
    logic                  snap_lz, snap_lz_nxt;
    logic [THR_W-1:0]      thr, thr_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic                  frame_start_nxt;

    logic [PROD_W-1:0]     duty_prod;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;

    // Active-low {g,f,e,d,c,b,a} pattern for a BCD nibble; non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // On-time threshold for the PWM window inside one digit slot.
    assign duty_prod = (PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(SCAN_DIV);

    // Leading-zero mask: digits above the first nonzero nibble, never digit 0.
    always_comb begin : lz_scan
        logic lead;
        lead    = 1'b1;
        lz_dark = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead       = lead && (snap_bcd[4*k +: 4] == 4'd0);
            lz_dark[k] = snap_lz && lead && (k != 0);
        end
    end

    // Per-digit attributes of the currently selected slot.
    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel == SEL_W'(k)) begin
                cur_nib   = snap_bcd[4*k +: 4];
                cur_dp    = snap_dp[k];
                cur_blink = snap_blink[k];
                cur_lz    = lz_dark[k];
            end
        end
    end

    // Next-state: scan counters, frame snapshot, blink timing and output drive.
    always_comb begin
        pc_nxt          = pc;
        sel_nxt         = sel;
        blink_cnt_nxt   = blink_cnt;
        blink_ph_nxt    = blink_ph;
        snap_bcd_nxt    = snap_bcd;
        snap_dp_nxt     = snap_dp;
        snap_blink_nxt  = snap_blink;
        snap_lz_nxt     = snap_lz;
        thr_nxt         = thr;
        an_nxt          = '1;
        seg_nxt         = 7'h7F;
        dp_nxt          = 1'b1;
        frame_start_nxt = 1'b0;

        if (!en) begin
            pc_nxt        = '0;
            sel_nxt       = '0;
            blink_cnt_nxt = '0;
        end else begin
            if (pc == PC_W'(SCAN_DIV - 1)) begin
                pc_nxt  = '0;
                sel_nxt = (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + SEL_W'(1);
            end else begin
                pc_nxt = pc + PC_W'(1);
            end

            if (pc == '0) begin
                thr_nxt = THR_W'(duty_prod >> BRIGHT_W);
            end

            if (pc == '0 && sel == '0) begin
                snap_bcd_nxt    = bcd_data;
                snap_dp_nxt     = dp_mask;
                snap_blink_nxt  = blink_mask;
                snap_lz_nxt     = lz_blank;
                frame_start_nxt = 1'b1;
                if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_nxt = '0;
                    blink_ph_nxt  = ~blink_ph;
                end else begin
                    blink_cnt_nxt = blink_cnt + BC_W'(1);
                end
            end

            // Dead cycle at pc = 0, PWM window, and blink-off digits stay dark.
            if (pc != '0 && THR_W'(pc) < thr && !(blink_ph && cur_blink)) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (sel == SEL_W'(k)) begin
                        an_nxt[k] = 1'b0;
                    end
                end
                seg_nxt = cur_lz ? 7'h7F : seg_decode(cur_nib);
                dp_nxt  = ~cur_dp;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            sel         <= '0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b0;
            snap_bcd    <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
            thr         <= '0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            sel         <= sel_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_ph    <= blink_ph_nxt;
            snap_bcd    <= snap_bcd_nxt;
            snap_dp     <= snap_dp_nxt;
            snap_blink  <= snap_blink_nxt;
            snap_lz     <= snap_lz_nxt;
            thr         <= thr_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed scenarios plus random traffic, with a
// cycle-level reference model feeding a scoreboard checked on the falling edge.
module tb_fnd_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BW = 2;
    localparam int BF = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [15:0]   bcd_data;
    logic [3:0]    dp_mask;
    logic [3:0]    blink_mask;
    logic          lz_blank;
    logic [BW-1:0] brightness;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    exp_t sb[$];

    // Reference model state
    int         m_t      = 0;
    int         m_thr    = 0;
    int         m_frames = 0;
    bit         m_phase  = 1'b0;
    logic [15:0] m_bcd   = '0;
    logic [3:0]  m_dpm   = '0;
    logic [3:0]  m_blm   = '0;
    logic        m_lz    = 1'b0;

    fnd_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BRIGHT_W    (BW),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_data   (bcd_data),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Model: time since scan start gives slot and phase by plain arithmetic.
    always @(posedge clk) begin : model
        exp_t e;
        int   pcm;
        int   selm;
        int   nib;
        bit   lit;
        bit   lzb;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        if (rst) begin
            m_t = 0; m_frames = 0; m_phase = 1'b0;
            m_bcd = '0; m_dpm = '0; m_blm = '0; m_lz = 1'b0;
        end else if (!en) begin
            m_t = 0; m_frames = 0;
        end else begin
            pcm  = m_t % SD;
            selm = (m_t / SD) % ND;
            if (pcm == 0) m_thr = ((int'(brightness) + 1) * SD) >> BW;
            if (pcm == 0 && selm == 0) begin
                m_bcd = bcd_data; m_dpm = dp_mask; m_blm = blink_mask; m_lz = lz_blank;
                m_frames++;
                if (m_frames % BF == 0) m_phase = ~m_phase;
                e.fs = 1'b1;
            end
            lit = (pcm != 0) && (pcm < m_thr) && !(m_phase && m_blm[selm]);
            if (lit) begin
                nib  = int'((m_bcd >> (4 * selm)) & 16'hF);
                lzb  = m_lz && (selm != 0) && ((m_bcd >> (4 * selm)) == 16'h0);
                e.an  = ~(4'(1) << selm);
                e.seg = lzb ? 7'h7F : seg_of(nib);
                e.dp  = ~m_dpm[selm];
            end
            m_t++;
        end
        sb.push_back(e);
    end

    // Monitor: one registered output set per cycle, compared mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (rst) e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
            a = exp_t'({an, seg, dp, frame_start});
            total++;
            if (a !== e)
                $display("FAIL out cyc=%0d got an=%b seg=%h dp=%b fs=%b exp an=%b seg=%h dp=%b fs=%b",
                         cyc, a.an, a.seg, a.dp, a.fs, e.an, e.seg, e.dp, e.fs);
            else
                passed++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Align to a frame boundary, bounded so a dead scan cannot hang the run.
    task automatic wait_frame();
        int k;
        k = 0;
        while (frame_start !== 1'b1 && k < 100) begin
            step(1);
            k++;
        end
        if (frame_start !== 1'b1) begin
            total++;
            $display("FAIL wait_frame got no frame_start within %0d cycles", k);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; bcd_data = 16'h1234; dp_mask = '0; blink_mask = '0;
        lz_blank = 1'b0; brightness = 2'd3;
        step(3);
        rst = 1'b0;
        step(4 * ND * SD);

        brightness = 2'd0; step(2 * ND * SD);
        brightness = 2'd1; step(2 * ND * SD);
        brightness = 2'd3;

        lz_blank = 1'b1; bcd_data = 16'h0050; step(2 * ND * SD);
        bcd_data = 16'h0000; step(2 * ND * SD);
        lz_blank = 1'b0; bcd_data = 16'h1234;

        blink_mask = 4'b1100; dp_mask = 4'b0100; step(6 * ND * SD);
        blink_mask = '0; dp_mask = '0;

        wait_frame();
        step(2 * SD + 2);
        bcd_data = 16'h5678; step(2 * ND * SD);

        bcd_data = 16'h123A; step(ND * SD);
        step(5); en = 1'b0; step(3); en = 1'b1; step(2 * ND * SD);
        step(13); rst = 1'b1; step(2); rst = 1'b0; step(2 * ND * SD);

        repeat (60) begin
            bcd_data   = 16'($urandom);
            dp_mask    = 4'($urandom);
            blink_mask = 4'($urandom);
            lz_blank   = 1'($urandom);
            brightness = BW'($urandom);
            if ($urandom_range(0, 9) == 0) bcd_data = 16'($urandom_range(0, 255));
            step($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0; step($urandom_range(1, 5)); en = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0;
            end
        end
        step(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
